// File: rtl/led_pkg.sv
// Shared constants and helpers for the key-to-LED driver.
// Optional LED_TOGGLE_EN selects toggle-on-press LEDs.
package led_pkg;

    localparam int NUM_KEYS = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 20000;
    localparam int DEF_SYNC_STAGES = 2;

    // Wide enough to hold DEBOUNCE_CYCLES itself.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/led_key_debounce.sv
// One key channel: synchroniser chain, stability counter, stable level.
// Stable follows the key only after DEBOUNCE_CYCLES matching samples.
module key_debounce
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic stable
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], key};
        end
    end

    assign sample = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            stable <= 1'b1;
        end else if (sample == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            stable <= sample;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led.sv
// Four-channel debounced push-button to LED driver.
// Define LED_TOGGLE_EN for toggle-on-press instead of momentary LEDs.
module led
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key1,
    input  logic key2,
    input  logic key3,
    input  logic key4,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic led4
);

    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] leds;

    assign keys = {key4, key3, key2, key1};

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_deb (
            .clk(clk),
            .rst_n(rst_n),
            .key(keys[i]),
            .stable(stable[i])
        );
    end

`ifdef LED_TOGGLE_EN
    logic [NUM_KEYS-1:0] stable_d;
    logic [NUM_KEYS-1:0] press;

    // Falling edge of stable seen one edge after acceptance, matching momentary latency.
    assign press = stable_d & ~stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= '1;
            leds <= '0;
        end else begin
            stable_d <= stable;
            leds <= leds ^ press;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds <= '0;
        end else begin
            leds <= ~stable;
        end
    end
`endif

    assign led1 = leds[0];
    assign led2 = leds[1];
    assign led3 = leds[2];
    assign led4 = leds[3];

endmodule

// File: tb/tb_led.sv
// Directed self-checking bench for led with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Latency from first sampling edge to LED is 7 rising edges.
module tb_led;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key1 = 1'b1;
    logic key2 = 1'b1;
    logic key3 = 1'b1;
    logic key4 = 1'b1;
    logic led1;
    logic led2;
    logic led3;
    logic led4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key1(key1),
        .key2(key2),
        .key3(key3),
        .key4(key4),
        .led1(led1),
        .led2(led2),
        .led3(led3),
        .led4(led4)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {led4, led3, led2, led1};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #2;
        check("reset", 4'b0000);
        #5;
        rst_n = 1'b1;
        step(3);
        check("idle", 4'b0000);

`ifdef LED_TOGGLE_EN
        key1 = 1'b0;
        step(6);
        check("t_press1_pre", 4'b0000);
        step(1);
        check("t_press1", 4'b0001);
        key1 = 1'b1;
        step(7);
        check("t_rel1", 4'b0001);
        step(10);
        check("t_rel1_hold", 4'b0001);
        key1 = 1'b0;
        step(6);
        check("t_press2_pre", 4'b0001);
        step(1);
        check("t_press2", 4'b0000);
        key1 = 1'b1;
        step(7);
        check("t_rel2", 4'b0000);
        step(10);
        check("t_rel2_hold", 4'b0000);
`else
        key4 = 1'b0;
        step(6);
        check("k4_pre", 4'b0000);
        step(1);
        check("k4_on", 4'b1000);
        key4 = 1'b1;
        step(6);
        check("k4_rel_pre", 4'b1000);
        step(1);
        check("k4_off", 4'b0000);

        key3 = 1'b0;
        step(6);
        check("k3_pre", 4'b0000);
        step(1);
        check("k3_on", 4'b0100);
        step(43);
        check("k3_hold", 4'b0100);
        key3 = 1'b1;
        key2 = 1'b0;
        step(6);
        check("k2_pre", 4'b0100);
        step(1);
        check("k2_on", 4'b0010);
        step(43);
        check("k2_hold", 4'b0010);
        key2 = 1'b1;
        key1 = 1'b0;
        step(6);
        check("k1_pre", 4'b0010);
        step(1);
        check("k1_on", 4'b0001);
        step(43);
        check("k1_hold", 4'b0001);
        key1 = 1'b1;
        step(7);
        check("walk_end", 4'b0000);

        key2 = 1'b0;
        step(3);
        key2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("glitch", 4'b0000);
            step(1);
        end

        {key4, key3, key2, key1} = 4'b0000;
        step(6);
        check("all_pre", 4'b0000);
        step(1);
        check("all_on", 4'b1111);
        step(5);
        check("all_hold", 4'b1111);
`endif

        {key4, key3, key2, key1} = 4'b0000;
        step(10);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", 4'b0000);
        {key4, key3, key2, key1} = 4'b1111;
        #2;
        rst_n = 1'b1;
        step(10);
        check("post_rst", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
